// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU constants, the fetch FSM encoding and the illegal-fetch predicate.
// Imported by the fetch stage, its IF/ID register and the interface.
package if_fetch_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    // Misaligned, or beyond the last whole word of instruction memory.
    function automatic logic fetch_illegal(input logic [ADDR_W-1:0] pc,
                                           input logic [ADDR_W-1:0] last_pc);
        return (pc[1:0] != 2'b00) || (pc > last_pc);
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-ROM port and IF/ID outputs.
// The master side is the surrounding pipeline/ROM; the slave side is the fetch stage.
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    logic               stall;
    logic               flush;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [ADDR_W-1:0]  im_addr;
    logic [INSTR_W-1:0] im_data;
    logic               if_id_valid;
    logic [INSTR_W-1:0] if_id_instr;
    logic [ADDR_W-1:0]  if_id_pc;
    logic [ADDR_W-1:0]  if_id_pc4;
    logic               fetch_fault;
    logic [ADDR_W-1:0]  fault_pc;
    logic [31:0]        fetch_count;

    modport master (
        output stall, flush, redirect_valid, redirect_pc, im_data,
        input  im_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4,
               fetch_fault, fault_pc, fetch_count
    );

    modport slave (
        input  stall, flush, redirect_valid, redirect_pc, im_data,
        output im_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4,
               fetch_fault, fault_pc, fetch_count
    );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load; with neither asserted the entry holds.
// A bubble clears valid/instr but keeps the pc fields of the previous entry.
module if_fetch_stage_if_id_reg
    import if_fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bubble_i,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  pc4_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc4_q, pc4_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        if (bubble_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
            pc4_d   = pc_i + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, BOOT/RUN/HALTED FSM, fault capture and fetch counter.
// ROM word at im_addr reaches IF/ID one cycle later; stall holds PC and IF/ID, one fetch per cycle.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IM_BYTES = 1024
) (
    input logic           clk,
    input logic           rst_n,
    if_fetch_stage_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IM_BYTES - 4);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]       count_q, count_d;
    logic              bubble, load;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;
        bubble     = 1'b0;
        load       = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A taken redirect discards the wrong-path word before it is checked.
                if (bus.redirect_valid) begin
                    pc_d   = bus.redirect_pc;
                    bubble = 1'b1;
                end else if (fetch_illegal(pc_q, LAST_PC)) begin
                    bubble     = 1'b1;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                    state_d    = ST_HALTED;
                end else if (bus.stall && bus.flush) begin
                    bubble = 1'b1;
                end else if (bus.stall) begin
                    bubble = 1'b0;
                end else if (bus.flush) begin
                    bubble = 1'b1;
                end else begin
                    load    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    count_d = count_q + 32'd1;
                end
            end
            default: begin
                bubble  = 1'b1;
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    if_fetch_stage_if_id_reg u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (bubble),
        .load_i   (load),
        .instr_i  (bus.im_data),
        .pc_i     (pc_q),
        .valid_o  (bus.if_id_valid),
        .instr_o  (bus.if_id_instr),
        .pc_o     (bus.if_id_pc),
        .pc4_o    (bus.if_id_pc4)
    );

    assign bus.im_addr     = pc_q;
    assign bus.fetch_fault = fault_q;
    assign bus.fault_pc    = fault_pc_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed vector bench for if_fetch_stage with a combinational ROM model.
module tb_if_fetch_stage;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic        e_flt;
        logic [31:0] e_fpc;
        logic [31:0] e_cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    if_fetch_stage_if bus();

    if_fetch_stage #(.RESET_PC(32'h0), .IM_BYTES(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] rw(input logic [31:0] a);
        return {a[9:2] ^ 8'hE7, a[9:2], 8'h13, a[7:0] ^ 8'h5A};
    endfunction

    assign bus.im_data = rw(bus.im_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic f, input logic v,
                                input logic [31:0] rpc, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                                input logic [31:0] ep4, input logic ef, input logic [31:0] efp,
                                input logic [31:0] ec);
        vec_t t;
        t.rst_n = r;  t.stall = s;  t.flush = f;  t.rv = v;  t.rpc = rpc;
        t.e_addr = ea; t.e_vld = ev; t.e_instr = ei; t.e_pc = ep; t.e_pc4 = ep4;
        t.e_flt = ef; t.e_fpc = efp; t.e_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        @(negedge clk);
        rst_n              = t.rst_n;
        bus.stall          = t.stall;
        bus.flush          = t.flush;
        bus.redirect_valid = t.rv;
        bus.redirect_pc    = t.rpc;
        @(posedge clk);
        #1;
        chk("im_addr",     idx, bus.im_addr,           t.e_addr);
        chk("if_id_valid", idx, {31'b0, bus.if_id_valid}, {31'b0, t.e_vld});
        chk("if_id_instr", idx, bus.if_id_instr,       t.e_instr);
        chk("if_id_pc",    idx, bus.if_id_pc,          t.e_pc);
        chk("if_id_pc4",   idx, bus.if_id_pc4,         t.e_pc4);
        chk("fetch_fault", idx, {31'b0, bus.fetch_fault}, {31'b0, t.e_flt});
        chk("fault_pc",    idx, bus.fault_pc,          t.e_fpc);
        chk("fetch_count", idx, bus.fetch_count,       t.e_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;

        //           rst st fl rv rpc       addr  vld instr      pc     pc4    flt fpc    cnt
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,     32'h0,  32'h0,  0, 32'h0,  0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,     32'h0,  32'h0,  0, 32'h0,  0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'h4,  1, rw(32'h0), 32'h0,  32'h4,  0, 32'h0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'h8,  1, rw(32'h4), 32'h4,  32'h8,  0, 32'h0,  2));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,   32'h8,  1, rw(32'h4), 32'h4,  32'h8,  0, 32'h0,  2));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,   32'h8,  1, rw(32'h4), 32'h4,  32'h8,  0, 32'h0,  2));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'hC,  1, rw(32'h8), 32'h8,  32'hC,  0, 32'h0,  3));
        vecs.push_back(mk(1, 1, 0, 1, 32'h40,  32'h40, 0, 32'h0,     32'h8,  32'hC,  0, 32'h0,  3));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'h44, 1, rw(32'h40),32'h40, 32'h44, 0, 32'h0,  4));
        vecs.push_back(mk(1, 0, 0, 1, 32'h10,  32'h10, 0, 32'h0,     32'h40, 32'h44, 0, 32'h0,  4));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,   32'h10, 0, 32'h0,     32'h40, 32'h44, 0, 32'h0,  4));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'h14, 1, rw(32'h10),32'h10, 32'h14, 0, 32'h0,  5));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,   32'h14, 0, 32'h0,     32'h10, 32'h14, 0, 32'h0,  5));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'h18, 1, rw(32'h14),32'h14, 32'h18, 0, 32'h0,  6));
        vecs.push_back(mk(1, 0, 0, 1, 32'h22,  32'h22, 0, 32'h0,     32'h14, 32'h18, 0, 32'h0,  6));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'h22, 0, 32'h0,     32'h14, 32'h18, 1, 32'h22, 6));
        vecs.push_back(mk(1, 1, 0, 1, 32'h100, 32'h22, 0, 32'h0,     32'h14, 32'h18, 1, 32'h22, 6));
        vecs.push_back(mk(1, 0, 1, 1, 32'h80,  32'h22, 0, 32'h0,     32'h14, 32'h18, 1, 32'h22, 6));
        vecs.push_back(mk(0, 1, 0, 1, 32'h80,  32'h0,  0, 32'h0,     32'h0,  32'h0,  0, 32'h0,  0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,     32'h0,  32'h0,  0, 32'h0,  0));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // End of memory: the last legal word is latched, then the next PC faults.
        run_vec(mk(1, 0, 0, 1, 32'h3F8, 32'h3F8, 0, 32'h0,      32'h0,   32'h0,   0, 32'h0,   0), 100);
        run_vec(mk(1, 0, 0, 0, 32'h0,   32'h3FC, 1, rw(32'h3F8),32'h3F8, 32'h3FC, 0, 32'h0,   1), 101);
        run_vec(mk(1, 0, 0, 0, 32'h0,   32'h400, 1, rw(32'h3FC),32'h3FC, 32'h400, 0, 32'h0,   2), 102);
        run_vec(mk(1, 0, 0, 0, 32'h0,   32'h400, 0, 32'h0,      32'h3FC, 32'h400, 1, 32'h400, 2), 103);
        run_vec(mk(1, 0, 0, 0, 32'h0,   32'h400, 0, 32'h0,      32'h3FC, 32'h400, 1, 32'h400, 2), 104);

        // One-cycle reset from HALTED, then BOOT, then fetching restarts at RESET_PC.
        run_vec(mk(0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,      32'h0,   32'h0,   0, 32'h0,   0), 105);
        run_vec(mk(1, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,      32'h0,   32'h0,   0, 32'h0,   0), 106);
        run_vec(mk(1, 0, 0, 0, 32'h0,   32'h4,   1, rw(32'h0),  32'h0,   32'h4,   0, 32'h0,   1), 107);

        // Redirect to a target past the end is taken, then faults the next cycle.
        run_vec(mk(1, 0, 0, 1, 32'h400, 32'h400, 0, 32'h0,      32'h0,   32'h4,   0, 32'h0,   1), 108);
        run_vec(mk(1, 1, 0, 0, 32'h0,   32'h400, 0, 32'h0,      32'h0,   32'h4,   1, 32'h400, 1), 109);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
